// File: rtl/seq_counter.sv
// Multi-sequence up/down counter: binary, odd, even and reflected-Gray sequences,
// synchronous load, and a sticky flag for steps taken from out-of-sequence states.
module seq_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] nxt,
   output logic             tc,
   output logic             illegal
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
   localparam logic [WIDTH-1:0] MAXV = '1;
   localparam logic [WIDTH-1:0] MSB  = ONE << (WIDTH-1);

   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] gbin;
   logic             ill_st;

   always_comb begin
      step   = '0;
      term   = '0;
      ill_st = 1'b0;
      gbin   = g2b(count);
      case (mode)
         2'b00: begin
            step = dir ? count - ONE : count + ONE;
            term = MAXV;
         end
         2'b01: begin
            // 0 sits between the top odd value and 1, so both ends need explicit wrap
            ill_st = ~count[0] && (count != '0);
            if (!dir) step = (count == MAXV) ? '0 : (count == '0) ? ONE : count + TWO;
            else      step = (count == ONE) ? '0 : (count == '0) ? MAXV : count - TWO;
            term = MAXV;
         end
         2'b10: begin
            ill_st = count[0];
            step   = dir ? count - TWO : count + TWO;
            term   = MAXV - ONE;
         end
         2'b11: begin
            step = b2g(dir ? gbin - ONE : gbin + ONE);
            term = MSB;
         end
         default: begin
            step = '0;
            term = '0;
         end
      endcase
      if (dir) term = '0;
   end

   assign nxt = ill_st ? '0 : step;
   assign tc  = en & ~ill_st & (count == term);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         illegal <= 1'b0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= nxt;
         if (ill_st) illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_counter.sv
// Directed bench for seq_counter: WIDTH=3 and WIDTH=4 instances driven from shared controls.
module tb_seq_counter;

   logic       clk = 1'b0;
   logic       rst, en, dir, load;
   logic [1:0] mode;
   logic [2:0] lv3, cnt3, nxt3;
   logic [3:0] lv4, cnt4, nxt4;
   logic       tc3, tc4, ill3, ill4;
   logic [2:0] prev;
   logic [2:0] exp_odd  [6] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd1};
   logic [2:0] exp_gray [8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   seq_counter #(.WIDTH(3)) u3 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(lv3), .count(cnt3), .nxt(nxt3), .tc(tc3), .illegal(ill3)
   );

   seq_counter #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
      .load_val(lv4), .count(cnt4), .nxt(nxt4), .tc(tc4), .illegal(ill4)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; mode = 2'b01; lv3 = '0; lv4 = '0;
      #12;
      chk("rst_count", 16'(cnt3), 16'd0);
      chk("rst_illegal", 16'(ill3), 16'd0);
      chk("rst_nxt_fwd", 16'(nxt3), 16'd1);
      chk("rst_tc_en0", 16'(tc3), 16'd0);
      en = 1'b1; dir = 1'b1; #1;
      chk("rst_tc_rev", 16'(tc3), 16'd1);
      chk("rst_nxt_rev", 16'(nxt3), 16'd7);
      en = 1'b0; dir = 1'b0;

      // odd forward sequence from reset
      @(negedge clk); rst = 1'b1; en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("odd_fwd", 16'(cnt3), 16'(exp_odd[i]));
         chk("odd_tc", 16'(tc3), 16'(exp_odd[i] == 3'd7));
      end
      en = 1'b0;

      // load an illegal odd-mode value, then step out of it
      load = 1'b1; lv3 = 3'd4;
      @(negedge clk); load = 1'b0;
      chk("ld_count", 16'(cnt3), 16'd4);
      chk("ld_no_ill", 16'(ill3), 16'd0);
      chk("ld_nxt_rec", 16'(nxt3), 16'd0);
      en = 1'b1; #1;
      chk("ld_tc_ill", 16'(tc3), 16'd0);
      @(negedge clk);
      chk("rec_count", 16'(cnt3), 16'd0);
      chk("rec_ill", 16'(ill3), 16'd1);
      @(negedge clk);
      chk("rec_step", 16'(cnt3), 16'd1);
      chk("ill_sticky", 16'(ill3), 16'd1);

      // load beats step on the same edge, then hold
      load = 1'b1; lv3 = 3'd5;
      @(negedge clk);
      chk("ld_pri", 16'(cnt3), 16'd5);
      load = 1'b0; en = 1'b0;
      @(negedge clk);
      chk("hold", 16'(cnt3), 16'd5);

      // Gray forward from 0
      load = 1'b1; lv3 = 3'd0; mode = 2'b11;
      @(negedge clk); load = 1'b0; en = 1'b1;
      prev = cnt3;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("gray_fwd", 16'(cnt3), 16'(exp_gray[i]));
         chk("gray_1bit", 16'($countones(prev ^ cnt3)), 16'd1);
         chk("gray_tc", 16'(tc3), 16'(exp_gray[i] == 3'd4));
         prev = cnt3;
      end
      dir = 1'b1;
      @(negedge clk);
      chk("gray_rev", 16'(cnt3), 16'd4);
      chk("gray_ill", 16'(ill3), 16'd1);
      en = 1'b0; dir = 1'b0;

      // asynchronous reset mid-sequence
      load = 1'b1; lv3 = 3'd6; mode = 2'b00;
      @(negedge clk); load = 1'b0;
      chk("pre_rst", 16'(cnt3), 16'd6);
      #2 rst = 1'b0;
      #1;
      chk("async_cnt", 16'(cnt3), 16'd0);
      chk("async_ill", 16'(ill3), 16'd0);
      #1 rst = 1'b1; en = 1'b1;
      @(negedge clk);
      chk("post_rst", 16'(cnt3), 16'd1);
      en = 1'b0;

      // WIDTH=4 even reverse, then switch to odd at 10
      load = 1'b1; lv3 = '0; lv4 = '0; mode = 2'b10; dir = 1'b1;
      @(negedge clk); load = 1'b0; en = 1'b1; #1;
      chk("w4_nxt", 16'(nxt4), 16'd14);
      chk("w4_tc_rev", 16'(tc4), 16'd1);
      @(negedge clk); chk("w4_even", 16'(cnt4), 16'd14);
      @(negedge clk); chk("w4_even", 16'(cnt4), 16'd12);
      @(negedge clk); chk("w4_even", 16'(cnt4), 16'd10);
      chk("w3_even", 16'(cnt3), 16'd2);
      mode = 2'b01; #1;
      chk("w4_sw_nxt", 16'(nxt4), 16'd0);
      chk("w4_ill_pre", 16'(ill4), 16'd0);
      @(negedge clk);
      chk("w4_sw_cnt", 16'(cnt4), 16'd0);
      chk("w4_sw_ill", 16'(ill4), 16'd1);
      en = 1'b0;

      // binary reverse wrap
      load = 1'b1; mode = 2'b00;
      @(negedge clk); load = 1'b0; en = 1'b1;
      @(negedge clk);
      chk("bin_wrap", 16'(cnt3), 16'd7);
      en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
